// File: rtl/spi_rx_slave_fifo_if.sv
// Bus bundle for the SPI receive slave with its FIFO consumer side.
// The slave modport is the receiver's view; master is the SPI host plus FIFO consumer.
interface spi_rx_slave_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) ();
  logic                         SCK;
  logic                         SSEL;
  logic                         MOSI;
  logic                         ACK;
  logic                         CLR_OVF;
  logic [WIDTH-1:0]             DATA;
  logic                         VALID;
  logic [$clog2(DEPTH+1)-1:0]   LEVEL;
  logic                         OVERFLOW;
  logic                         FRAME_ERR;

  modport slave (
    input  SCK, SSEL, MOSI, ACK, CLR_OVF,
    output DATA, VALID, LEVEL, OVERFLOW, FRAME_ERR
  );

  modport master (
    output SCK, SSEL, MOSI, ACK, CLR_OVF,
    input  DATA, VALID, LEVEL, OVERFLOW, FRAME_ERR
  );
endinterface

// File: rtl/spi_rx_slave_fifo.sv
// SPI receive-only slave, oversampled on clk, pushing completed words into a
// first-word-fall-through FIFO with sticky overflow and a frame-error pulse.
module spi_rx_slave_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_rx_slave_fifo_if.slave    bus
);

  localparam int   PW     = $clog2(DEPTH);
  localparam int   LW     = $clog2(DEPTH + 1);
  localparam int   CW     = $clog2(WIDTH);
  localparam logic CPOL_L = (CPOL != 0);

  logic [2:0]       sck_sync_q, sck_sync_d;
  logic [2:0]       ssel_sync_q, ssel_sync_d;
  logic [1:0]       mosi_sync_q, mosi_sync_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             push_q, push_d;
  logic             frame_err_q, frame_err_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             sck_n1, sck_n2;
  logic             sample_edge;
  logic             ssel_active;
  logic             ssel_rise;
  logic [WIDTH-1:0] shift_next;
  logic             valid;
  logic             full;
  logic             pop;
  logic             wr_en;

  // Edge and select detection work on the normalised SCK (idle level = 0).
  always_comb begin
    sck_sync_d  = {sck_sync_q[1:0], bus.SCK};
    ssel_sync_d = {ssel_sync_q[1:0], bus.SSEL};
    mosi_sync_d = {mosi_sync_q[0], bus.MOSI};
    sck_n1      = sck_sync_q[1] ^ CPOL_L;
    sck_n2      = sck_sync_q[2] ^ CPOL_L;
    sample_edge = (CPHA != 0) ? (~sck_n1 & sck_n2) : (sck_n1 & ~sck_n2);
    ssel_active = ~ssel_sync_q[1];
    ssel_rise   = ssel_sync_q[1] & ~ssel_sync_q[2];
    if (MSB_FIRST != 0) begin
      shift_next = {shreg_q[WIDTH-2:0], mosi_sync_q[1]};
    end else begin
      shift_next = {mosi_sync_q[1], shreg_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    word_d      = word_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    if (!ssel_active) begin
      cnt_d       = '0;
      frame_err_d = ssel_rise && (cnt_q != '0);
    end else if (sample_edge) begin
      shreg_d = shift_next;
      if (cnt_q == CW'(WIDTH - 1)) begin
        cnt_d  = '0;
        push_d = 1'b1;
        word_d = shift_next;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // A pop frees a slot in the same cycle, so a full FIFO still accepts the push.
  always_comb begin
    valid    = (count_q != '0);
    full     = (count_q == LW'(DEPTH));
    pop      = valid & bus.ACK;
    wr_en    = push_q & (~full | pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({wr_en, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
    if (push_q && full && !pop) begin
      ovf_d = 1'b1;
    end else if (bus.CLR_OVF) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= {3{CPOL_L}};
      ssel_sync_q <= 3'b111;
      mosi_sync_q <= '0;
      cnt_q       <= '0;
      shreg_q     <= '0;
      word_q      <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      ssel_sync_q <= ssel_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      word_q      <= word_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= word_q;
    end
  end

  assign bus.DATA      = valid ? mem_q[rd_ptr_q] : '0;
  assign bus.VALID     = valid;
  assign bus.LEVEL     = count_q;
  assign bus.OVERFLOW  = ovf_q;
  assign bus.FRAME_ERR = frame_err_q;

endmodule

// File: doc/spi_rx_slave_fifo.md
SPI_RX_SLAVE_FIFO -- requirements
Module: spi_rx_slave_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning SPI word length in bits (2..32).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning receive FIFO entries (power of two, 2..64).
REQ-003 The block SHALL have parameter CPOL, default 0, meaning idle level of SCK.
REQ-004 The block SHALL have parameter CPHA, default 0, meaning sampling edge select (0 = leading edge, 1 = trailing edge).
REQ-005 The block SHALL have parameter MSB_FIRST, default 1, meaning bit order on MOSI (1 = MSB first, 0 = LSB first).
REQ-006 clk  input  1  sole system clock; all logic is on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 SCK  input  1  SPI clock, asynchronous to clk.
REQ-009 SSEL  input  1  SPI slave select, active low, asynchronous.
REQ-010 MOSI  input  1  SPI serial data in, asynchronous.
REQ-011 DATA  output  WIDTH  FIFO head word, valid only while VALID=1.
REQ-012 VALID  output  1  FIFO non-empty.
REQ-013 ACK  input  1  consumer pop; acts only when VALID=1.
REQ-014 LEVEL  output  $clog2(DEPTH+1)  current FIFO occupancy.
REQ-015 OVERFLOW  output  1  sticky flag: a received word was dropped.
REQ-016 CLR_OVF  input  1  synchronous clear of OVERFLOW.
REQ-017 FRAME_ERR  output  1  one-cycle pulse: SSEL deasserted mid-word.

Function
REQ-018 SCK and SSEL SHALL pass through 3-flop synchronisers and MOSI through a 2-flop synchroniser; edges SHALL be detected on stages [2:1].
REQ-019 The sampling edge SHALL be: SCK^CPOL rising when CPHA=0, and SCK^CPOL falling when CPHA=1.
REQ-020 SSEL is active in a cycle when synchronised SSEL stage [1] = 0.
REQ-021 On each sampling edge with SSEL active, the bit counter SHALL increment and the synchronised MOSI SHALL be shifted in: into bit 0, shifting left, when MSB_FIRST=1; into bit WIDTH-1, shifting right, when MSB_FIRST=0.
REQ-022 When a sampling edge occurs with bit counter = WIDTH-1, the counter SHALL wrap to 0 and a registered push strobe SHALL assert for exactly one cycle on the following cycle.
REQ-023 The completed word SHALL be written to the FIFO on the clk edge that ends the push-strobe cycle; VALID SHALL be 1 in the next cycle if the FIFO was empty (latency: sampling-edge detect cycle N -> VALID in cycle N+2).
REQ-024 The FIFO SHALL be first-word-fall-through: DATA equals the oldest entry whenever VALID=1; DATA is don't-care when VALID=0.
REQ-025 A pop SHALL occur on a clk edge where VALID=1 and ACK=1; ACK with VALID=0 SHALL have no effect.
REQ-026 A simultaneous push and pop SHALL both take effect, including when full: no drop, LEVEL unchanged.
REQ-027 A push while full without a pop SHALL discard the new word, leave FIFO contents unchanged, and set OVERFLOW.
REQ-028 OVERFLOW SHALL stay set until CLR_OVF=1; if set and clear occur in the same cycle, set SHALL win.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH; LEVEL SHALL range 0..DEPTH.
REQ-030 While SSEL is inactive, the bit counter SHALL be held at 0; partially shifted bits SHALL be discarded and never pushed.
REQ-031 On an SSEL active-to-inactive transition with bit counter != 0, FRAME_ERR SHALL pulse for one cycle; when the counter = 0, no pulse SHALL occur.
REQ-032 Sampling edges while SSEL is inactive SHALL be ignored.

Reset
REQ-033 On rst=1, FIFO SHALL be emptied and the following SHALL be 0: pointers, bit counter, push strobe, VALID, LEVEL, OVERFLOW, FRAME_ERR; DATA SHALL be 0.
REQ-034 On rst=1, the SCK synchroniser SHALL load CPOL and the SSEL synchroniser SHALL load 1, so that no spurious edge or select occurs after release.
REQ-035 Reset asserted mid-frame SHALL abort the frame with no push and no FRAME_ERR pulse; reception SHALL resume at the next bit after SSEL is re-asserted.

Verification
REQ-036 Mode 0, WIDTH=8, send 0xA5 MSB-first -> VALID rises 2 clk after the 8th sampling edge, DATA=0xA5, LEVEL=1; ACK pops -> VALID=0.
REQ-037 For each mode CPOL/CPHA in {00,01,10,11}, send 0x3C -> DATA=0x3C; MSB_FIRST=0 with bit stream 0,0,1,1,1,1,0,0 -> DATA=0x3C.
REQ-038 DEPTH=4, send 5 words 0x01..0x05 with no ACK -> LEVEL=4, OVERFLOW=1, pops return 0x01..0x04; CLR_OVF -> OVERFLOW=0.
REQ-039 FIFO full, push strobe coincident with ACK -> no overflow, LEVEL stays 4, next pops return entries in order with the new word last.
REQ-040 Deassert SSEL after 5 bits -> FRAME_ERR one-cycle pulse, LEVEL unchanged; next full word 0x81 is received intact.
REQ-041 Assert rst mid-word with 2 words queued -> VALID=0, LEVEL=0, OVERFLOW=0 immediately; no spurious push after release.
